// File: rtl/cal_num_accum.sv
// cal_num_accum: sums cfg_quantity unsigned samples after a start pulse and offers the total over a valid/ready handshake.
// Optional ignored-start counter on err_cnt is built only when CAL_NUM_ACCUM_ERR_CNT_EN is defined.
module cal_num_accum #(
  parameter int DATA_WIDTH = 8,
  parameter int SUM_WIDTH  = DATA_WIDTH + 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            cfg_quantity,
  input  logic                  cfg_start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  sum_valid,
  input  logic                  sum_ready,
  output logic [SUM_WIDTH-1:0]  sum_data,
  output logic                  busy,
  output logic [7:0]            err_cnt
);

  localparam int PAD_WIDTH = SUM_WIDTH - DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  state_t                 state_r;
  logic [3:0]             qty_r;
  logic [3:0]             cnt_r;
  logic [SUM_WIDTH-1:0]   acc_r;
  logic                   in_ready_r;
  logic                   sum_valid_r;
  logic [SUM_WIDTH-1:0]   sum_data_r;
  logic                   busy_r;

  logic                   accept_s;
  logic [3:0]             cnt_inc_s;
  logic [SUM_WIDTH-1:0]   acc_inc_s;

  // in_ready_r is high only in ACCUM, so this is the beat handshake.
  assign accept_s  = in_valid & in_ready_r;
  assign cnt_inc_s = cnt_r + 4'd1;
  assign acc_inc_s = acc_r + {{PAD_WIDTH{1'b0}}, in_data};

  // Control FSM; every output is registered alongside the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      qty_r       <= 4'd0;
      cnt_r       <= 4'd0;
      acc_r       <= '0;
      in_ready_r  <= 1'b0;
      sum_valid_r <= 1'b0;
      sum_data_r  <= '0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cfg_start) begin
            qty_r  <= cfg_quantity;
            cnt_r  <= 4'd0;
            acc_r  <= '0;
            busy_r <= 1'b1;
            if (cfg_quantity == 4'd0) begin
              state_r     <= OUTPUT;
              sum_valid_r <= 1'b1;
              sum_data_r  <= '0;
            end else begin
              state_r    <= ACCUM;
              in_ready_r <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ACCUM: begin
          if (accept_s) begin
            acc_r <= acc_inc_s;
            cnt_r <= cnt_inc_s;
            // Final beat: drop in_ready immediately so no extra beat slips in.
            if (cnt_inc_s == qty_r) begin
              state_r     <= OUTPUT;
              in_ready_r  <= 1'b0;
              sum_valid_r <= 1'b1;
              sum_data_r  <= acc_inc_s;
            end else begin
              state_r <= ACCUM;
            end
          end else begin
            state_r <= ACCUM;
          end
        end
        OUTPUT: begin
          if (sum_ready) begin
            state_r     <= IDLE;
            sum_valid_r <= 1'b0;
            sum_data_r  <= '0;
            busy_r      <= 1'b0;
          end else begin
            state_r <= OUTPUT;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b0;
          sum_valid_r <= 1'b0;
          sum_data_r  <= '0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign sum_valid = sum_valid_r;
  assign sum_data  = sum_data_r;
  assign busy      = busy_r;

`ifdef CAL_NUM_ACCUM_ERR_CNT_EN
  logic       start_ignored_s;
  logic [7:0] err_cnt_r;

  assign start_ignored_s = cfg_start & (state_r != IDLE);

  // Saturating count of start pulses that arrive while an operation is running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_r <= 8'h00;
    end else if (start_ignored_s && (err_cnt_r != 8'hFF)) begin
      err_cnt_r <= err_cnt_r + 8'd1;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign err_cnt = err_cnt_r;
`else
  assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_cal_num_accum.sv
// Directed bench for cal_num_accum: a vector table of complete transactions plus hand-written corner sequences.
module tb_cal_num_accum;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  cfg_quantity = 4'd0;
  logic        cfg_start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        sum_valid;
  logic        sum_ready = 1'b0;
  logic [11:0] sum_data;
  logic        busy;
  logic [7:0]  err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  cal_num_accum #(.DATA_WIDTH(8), .SUM_WIDTH(12)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_quantity(cfg_quantity), .cfg_start(cfg_start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sum_valid(sum_valid), .sum_ready(sum_ready), .sum_data(sum_data),
    .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

`ifdef CAL_NUM_ACCUM_ERR_CNT_EN
  localparam logic [7:0] ERR_EXP = 8'd3;
`else
  localparam logic [7:0] ERR_EXP = 8'd0;
`endif

  typedef struct {
    logic [3:0]  qty;
    logic [7:0]  d0;
    logic [7:0]  step;
    bit          gaps;
    logic [11:0] exp_sum;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic handshake(input string nm);
    sum_ready = 1'b1;
    @(negedge clk);
    sum_ready = 1'b0;
    chk({nm, " idle busy"}, busy, 0);
    chk({nm, " idle sum_valid"}, sum_valid, 0);
    chk({nm, " idle sum_data"}, sum_data, 0);
  endtask

  // Beat i carries d0 + i*step; inputs change on negedge, outputs sampled on negedge.
  task automatic run_txn(input logic [3:0] q, input logic [7:0] d0, input logic [7:0] st,
                         input bit gaps, input logic [11:0] exp_sum, input bit do_hs, input string nm);
    logic [7:0] d;
    int acc;
    int cyc;
    bit hit;
    @(negedge clk);
    cfg_quantity = q;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    if (q == 4'd0) begin
      chk({nm, " zero in_ready"}, in_ready, 0);
      chk({nm, " zero sum_valid"}, sum_valid, 1);
      chk({nm, " zero sum_data"}, sum_data, 0);
    end else begin
      chk({nm, " first in_ready"}, in_ready, 1);
      d = d0;
      acc = 0;
      cyc = 0;
      while (acc < int'(q) && cyc < 300) begin
        in_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
        in_data = d;
        hit = in_valid & in_ready;
        @(negedge clk);
        if (hit) begin
          acc++;
          d = d + st;
        end
        cyc++;
      end
      chk({nm, " beats accepted"}, acc, q);
      in_valid = 1'b1;
      in_data = 8'hAA;
      chk({nm, " in_ready after last"}, in_ready, 0);
      chk({nm, " sum_valid"}, sum_valid, 1);
      chk({nm, " sum_data"}, sum_data, exp_sum);
      @(negedge clk);
      in_valid = 1'b0;
      chk({nm, " sum_data held"}, sum_data, exp_sum);
    end
    if (do_hs) handshake(nm);
  endtask

  initial begin
    int cnt;
    bit hit;
    vecs[0] = '{qty: 4'd3,  d0: 8'h10, step: 8'h10, gaps: 1'b0, exp_sum: 12'h060};
    vecs[1] = '{qty: 4'd15, d0: 8'hFF, step: 8'h00, gaps: 1'b1, exp_sum: 12'hEF1};
    vecs[2] = '{qty: 4'd0,  d0: 8'h55, step: 8'h00, gaps: 1'b0, exp_sum: 12'h000};
    vecs[3] = '{qty: 4'd1,  d0: 8'h07, step: 8'h00, gaps: 1'b0, exp_sum: 12'h007};
    vecs[4] = '{qty: 4'd2,  d0: 8'h80, step: 8'h7F, gaps: 1'b1, exp_sum: 12'h17F};
    vecs[5] = '{qty: 4'd4,  d0: 8'h01, step: 8'h01, gaps: 1'b0, exp_sum: 12'h00A};

    #12;
    chk("reset busy", busy, 0);
    chk("reset in_ready", in_ready, 0);
    chk("reset sum_valid", sum_valid, 0);
    chk("reset sum_data", sum_data, 0);
    chk("reset err_cnt", err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_txn(vecs[i].qty, vecs[i].d0, vecs[i].step, vecs[i].gaps, vecs[i].exp_sum, 1'b1,
              $sformatf("vec%0d", i));

    // Backpressure with ignored starts, the last one in the handshake cycle.
    run_txn(4'd2, 8'h40, 8'h01, 1'b0, 12'h081, 1'b0, "bp");
    for (int i = 0; i < 10; i++) begin
      cfg_start = (i == 2 || i == 6);
      cfg_quantity = 4'hF;
      @(negedge clk);
      chk($sformatf("bp hold sum_valid %0d", i), sum_valid, 1);
      chk($sformatf("bp hold sum_data %0d", i), sum_data, 12'h081);
    end
    cfg_start = 1'b1;
    sum_ready = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    sum_ready = 1'b0;
    chk("bp busy after hs", busy, 0);
    chk("bp err_cnt", err_cnt, ERR_EXP);
    @(negedge clk);
    chk("bp start in hs ignored", busy, 0);

    // Reset in the middle of a run.
    @(negedge clk);
    cfg_quantity = 4'd5;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h21;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst mid busy", busy, 0);
    chk("rst mid in_ready", in_ready, 0);
    chk("rst mid sum_valid", sum_valid, 0);
    chk("rst mid sum_data", sum_data, 0);
    chk("rst mid err_cnt", err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst waits for start", busy, 0);
    run_txn(4'd1, 8'h07, 8'h00, 1'b0, 12'h007, 1'b1, "after rst");

    // cfg_quantity change mid-run must not matter.
    @(negedge clk);
    cfg_quantity = 4'd4;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    cfg_quantity = 4'd9;
    in_valid = 1'b1;
    in_data = 8'h11;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      hit = in_valid & in_ready;
      @(negedge clk);
      if (hit) cnt++;
    end
    in_valid = 1'b0;
    chk("qchg beats", cnt, 4);
    chk("qchg sum_valid", sum_valid, 1);
    chk("qchg sum_data", sum_data, 12'h044);
    handshake("qchg");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
